// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack handshake, one-cycle execute window
// Optional FETCH_HALT_EN: a taken self-jump parks the unit in HALT until reset.
module fetch_unit #(
   parameter int PC_W    = 10,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_req,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               s_inc,
   output logic [5:0]         opcode,
   output logic [INSTR_W-1:0] instr,
   output logic               exec,
   output logic [PC_W-1:0]    pc,
   output logic               halted
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] EXEC = 2'd2;
`ifdef FETCH_HALT_EN
   localparam logic [1:0] HALT = 2'd3;
`endif

   logic [1:0]         state;
   logic [PC_W-1:0]    pc_q;
   logic [INSTR_W-1:0] instr_q;
   logic               exec_q;
   logic [PC_W-1:0]    target;

   assign target = instr_q[PC_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         exec_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               // Acks outside REQ never touch the instruction register.
               if (imem_ack) begin
                  instr_q <= imem_data;
                  exec_q  <= 1'b1;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               exec_q <= 1'b0;
`ifdef FETCH_HALT_EN
               if (!s_inc && target == pc_q) begin
                  state <= HALT;
               end else begin
                  pc_q  <= s_inc ? pc_q + 1'b1 : target;
                  state <= REQ;
               end
`else
               pc_q  <= s_inc ? pc_q + 1'b1 : target;
               state <= REQ;
`endif
            end
            default: begin
`ifdef FETCH_HALT_EN
               state <= HALT;
`else
               state <= IDLE;
`endif
            end
         endcase
      end
   end

   assign imem_req  = (state == REQ);
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign instr     = instr_q;
   assign opcode    = instr_q[INSTR_W-1 -: 6];
   assign exec      = exec_q;
`ifdef FETCH_HALT_EN
   assign halted    = (state == HALT);
`else
   assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  imem_addr;
   logic        imem_req;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_data = 16'h0000;
   logic        s_inc = 1'b1;
   logic [5:0]  opcode;
   logic [15:0] instr;
   logic        exec;
   logic [9:0]  pc;
   logic        halted;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_unit #(.PC_W(10), .INSTR_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .imem_addr (imem_addr),
      .imem_req  (imem_req),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .s_inc     (s_inc),
      .opcode    (opcode),
      .instr     (instr),
      .exec      (exec),
      .pc        (pc),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in a REQ cycle; leaves the unit in the next REQ cycle.
   task automatic fetch(input logic [9:0] addr, input logic [15:0] word, input int waits,
                        input logic inc, input logic spur, input logic [9:0] next_addr);
      imem_ack = 1'b0;
      for (int i = 0; i < waits; i++) begin
         check("wait_req", imem_req, 1'b1);
         check("wait_addr", imem_addr, addr);
         check("wait_exec", exec, 1'b0);
         tick();
      end
      check("req", imem_req, 1'b1);
      check("addr", imem_addr, addr);
      imem_ack  = 1'b1;
      imem_data = word;
      tick();
      check("exec", exec, 1'b1);
      check("exec_req", imem_req, 1'b0);
      check("instr", instr, word);
      check("opcode", opcode, word[15:10]);
      imem_ack  = spur;
      imem_data = 16'hFFFF;
      s_inc     = inc;
      tick();
      imem_ack = 1'b0;
      s_inc    = ~inc;
      check("post_exec", exec, 1'b0);
      check("post_instr", instr, word);
      check("next_req", imem_req, 1'b1);
      check("next_addr", imem_addr, next_addr);
   endtask

   initial begin
      #2;
      check("rst_pc", pc, 0);
      check("rst_instr", instr, 0);
      check("rst_opcode", opcode, 0);
      check("rst_req", imem_req, 0);
      check("rst_exec", exec, 0);
      check("rst_halted", halted, 0);
      tick();
      reset = 1'b0;
      check("idle_req", imem_req, 0);
      tick();

      fetch(10'd0, 16'h0401, 0, 1'b1, 1'b0, 10'd1);
      fetch(10'd1, 16'h2C22, 0, 1'b1, 1'b1, 10'd2);
      fetch(10'd2, 16'h1037, 0, 1'b0, 1'b0, 10'h037);
      fetch(10'h037, 16'hFC00, 0, 1'b1, 1'b1, 10'h038);
      fetch(10'h038, 16'h13FF, 1, 1'b0, 1'b0, 10'h3FF);
      fetch(10'h3FF, 16'h8812, 0, 1'b1, 1'b0, 10'h000);
      fetch(10'h000, 16'h1005, 0, 1'b0, 1'b0, 10'h005);

`ifdef FETCH_HALT_EN
      imem_ack  = 1'b1;
      imem_data = 16'h1005;
      tick();
      imem_ack = 1'b0;
      s_inc    = 1'b0;
      check("halt_exec", exec, 1);
      tick();
      s_inc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         imem_ack = (i == 1);
         check("halted", halted, 1);
         check("halt_req", imem_req, 0);
         check("halt_exec_low", exec, 0);
         check("halt_pc", pc, 10'd5);
         tick();
      end
      imem_ack = 1'b0;
      check("halt_instr", instr, 16'h1005);
`else
      fetch(10'h005, 16'h1005, 0, 1'b0, 1'b0, 10'h005);
      check("no_halt", halted, 0);
      fetch(10'h005, 16'h1005, 0, 1'b0, 1'b0, 10'h005);
      check("no_halt2", halted, 0);
`endif

      // Async reset while a request waits
      reset = 1'b1;
      #1;
      check("rst_async_req", imem_req, 0);
      check("rst_async_pc", pc, 0);
      check("rst_async_halted", halted, 0);
      tick();
      reset = 1'b0;
      tick();
      fetch(10'd0, 16'h0C55, 3, 1'b1, 1'b0, 10'd1);

      // Async reset in the middle of EXEC discards the pending PC update
      imem_ack  = 1'b1;
      imem_data = 16'h1200;
      tick();
      imem_ack = 1'b0;
      s_inc    = 1'b0;
      check("mid_exec", exec, 1);
      #2;
      reset = 1'b1;
      #1;
      check("rst_exec_drop", exec, 0);
      check("rst_exec_instr", instr, 0);
      tick();
      reset = 1'b0;
      check("restart_idle", imem_req, 0);
      tick();
      check("restart_req", imem_req, 1);
      check("restart_addr", imem_addr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
